// File: rtl/fib_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : fib_seq_gen
// Purpose  : Parametrised two-term recurrence generator (Fibonacci-style)
//            feeding a first-word-fall-through output FIFO with a
//            valid/ready stream. Each push emits the current term `a`, then
//            advances a <- b, b <- f(a, b), where f is a+b (add mode) or
//            b-a (subtract mode). Arithmetic overflow/underflow sets a
//            sticky flag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH  term width in bits (>= 2)
//   DEPTH  output FIFO entries (power of two, >= 2)
//   SEED0  reset value of current term a
//   SEED1  reset value of next term b
//   CNT_W  width of the generated-term counter
// Ports
//   clk          clock
//   rst          asynchronous active-high reset
//   en_i         generate one term per cycle while FIFO has room
//   mode_i       0 = add (b' = a+b), 1 = subtract (b' = b-a)
//   load_i       synchronous reseed and flush, highest priority
//   seed0_i      value loaded into a on load_i
//   seed1_i      value loaded into b on load_i
//   out_valid_o  FIFO non-empty
//   out_ready_i  consumer accepts head while out_valid_o is high
//   out_data_o   FIFO head, 0 when empty
//   ovf_o        sticky overflow/underflow flag
//   term_cnt_o   terms pushed since reset/load (wraps)
// Configuration
//   FIB_SEQ_SAT_EN  when defined, overflowing results saturate (add clamps
//                   to all-ones, subtract clamps to 0) instead of wrapping.
//                   ovf_o is set either way.
// ============================================================================
module fib_seq_gen #(
   parameter int unsigned      WIDTH = 8,
   parameter int unsigned      DEPTH = 4,
   parameter logic [WIDTH-1:0] SEED0 = '0,
   parameter logic [WIDTH-1:0] SEED1 = WIDTH'(1),
   parameter int unsigned      CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             mode_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] seed0_i,
   input  logic [WIDTH-1:0] seed1_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic             ovf_o,
   output logic [CNT_W-1:0] term_cnt_o
);

   localparam int unsigned      PTR_W     = $clog2(DEPTH);
   localparam int unsigned      OCC_W     = PTR_W + 1;
   localparam logic [OCC_W-1:0] C_OCC_MAX = OCC_W'(DEPTH);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] a_q,      a_d;
   logic [WIDTH-1:0] b_q,      b_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] occ_q,    occ_d;
   logic             ovf_q,    ovf_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;

   logic [WIDTH-1:0] mem_q [DEPTH];

   // -------------------------------------------------------------------------
   // Handshake decode
   // -------------------------------------------------------------------------
   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;

   assign w_empty = (occ_q == '0);
   assign w_full  = (occ_q == C_OCC_MAX);
   assign w_pop   = ~w_empty & out_ready_i & ~load_i;
   // A full FIFO still accepts a push when the head leaves in the same cycle,
   // which keeps throughput at one term per cycle under continuous flow.
   assign w_push  = en_i & ~load_i & (~w_full | w_pop);

   // -------------------------------------------------------------------------
   // Recurrence step f(a, b)
   // -------------------------------------------------------------------------
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_diff;
   logic             w_borrow;
   logic [WIDTH-1:0] w_next_b;
   logic             w_step_ovf;

   assign w_sum    = {1'b0, a_q} + {1'b0, b_q};
   assign w_diff   = b_q - a_q;
   assign w_borrow = (a_q > b_q);

   always_comb begin
      w_next_b   = w_sum[WIDTH-1:0];
      w_step_ovf = 1'b0;
      if (mode_i) begin
         w_step_ovf = w_borrow;
`ifdef FIB_SEQ_SAT_EN
         w_next_b   = w_borrow ? '0 : w_diff;
`else
         w_next_b   = w_diff;
`endif
      end else begin
         w_step_ovf = w_sum[WIDTH];
`ifdef FIB_SEQ_SAT_EN
         w_next_b   = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
`else
         w_next_b   = w_sum[WIDTH-1:0];
`endif
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      ovf_d    = ovf_q;
      cnt_d    = cnt_q;

      if (load_i) begin
         a_d      = seed0_i;
         b_d      = seed1_i;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
         ovf_d    = 1'b0;
         cnt_d    = '0;
      end else begin
         if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            a_d      = b_q;
            b_d      = w_next_b;
            cnt_d    = cnt_q + CNT_W'(1);
            if (w_step_ovf) begin
               ovf_d = 1'b1;
            end
         end
         // Pointers wrap naturally because DEPTH is a power of two.
         case ({w_push, w_pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Control registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= SEED0;
         b_q      <= SEED1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         ovf_q    <= ovf_d;
         cnt_q    <= cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // FIFO storage
   // Not reset: contents are only observable through the occupancy count,
   // which reset and load both clear, so stale entries are never visible.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= a_q;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs (register-derived only)
   // -------------------------------------------------------------------------
   assign out_valid_o = ~w_empty;
   assign out_data_o  = w_empty ? '0 : mem_q[rd_ptr_q];
   assign ovf_o       = ovf_q;
   assign term_cnt_o  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fib_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_fib_seq_gen
// Purpose  : Self-checking bench for fib_seq_gen (default parameters).
//            Table-driven Fibonacci run, hand-written corner sequences and
//            randomized traffic, all compared against a queue-based
//            reference model of the generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fib_seq_gen;

   localparam int W     = 8;
   localparam int DEPTH = 4;
   localparam int MAXV  = (1 << W) - 1;

   logic          clk;
   logic          rst;
   logic          en_i;
   logic          mode_i;
   logic          load_i;
   logic [W-1:0]  seed0_i;
   logic [W-1:0]  seed1_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [W-1:0]  out_data_o;
   logic          ovf_o;
   logic [15:0]   term_cnt_o;

   fib_seq_gen dut (
      .clk         (clk),
      .rst         (rst),
      .en_i        (en_i),
      .mode_i      (mode_i),
      .load_i      (load_i),
      .seed0_i     (seed0_i),
      .seed1_i     (seed1_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .ovf_o       (ovf_o),
      .term_cnt_o  (term_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------------------------------------------------------------
   // Reference model: terms as plain integers, FIFO as a queue
   // ---------------------------------------------------------------------
   int ma;
   int mb;
   int mq[$];
   bit movf;
   int mcnt;

   function automatic void model_reset();
      ma   = 0;
      mb   = 1;
      mq.delete();
      movf = 1'b0;
      mcnt = 0;
   endfunction

   function automatic void model_edge(input bit en, input bit ready, input bit load,
                                      input bit mode, input int s0, input int s1);
      bit pop;
      bit full;
      bit push;
      int nb;
      pop  = (mq.size() > 0) && ready && !load;
      full = (mq.size() == DEPTH);
      push = en && !load && (!full || pop);
      if (load) begin
         ma   = s0;
         mb   = s1;
         mq.delete();
         movf = 1'b0;
         mcnt = 0;
         return;
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
         mq.push_back(ma);
         if (!mode) begin
            nb = ma + mb;
            if (nb > MAXV) begin
               movf = 1'b1;
`ifdef FIB_SEQ_SAT_EN
               nb = MAXV;
`else
               nb = nb - (MAXV + 1);
`endif
            end
         end else begin
            if (ma > mb) begin
               movf = 1'b1;
`ifdef FIB_SEQ_SAT_EN
               nb = 0;
`else
               nb = mb - ma + MAXV + 1;
`endif
            end else begin
               nb = mb - ma;
            end
         end
         ma   = mb;
         mb   = nb;
         mcnt = (mcnt + 1) % 65536;
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      int exp_data;
      exp_data = (mq.size() > 0) ? mq[0] : 0;
      chk("model_valid", 32'(out_valid_o), 32'(mq.size() > 0));
      chk("model_data",  32'(out_data_o),  32'(exp_data));
      chk("model_ovf",   32'(ovf_o),       32'(movf));
      chk("model_cnt",   32'(term_cnt_o),  32'(mcnt));
   endtask

   // One clock: drive inputs, take the edge, update model, compare #1 later.
   task automatic step(input bit en, input bit ready, input bit load, input bit mode,
                       input logic [W-1:0] s0, input logic [W-1:0] s1);
      en_i        = en;
      out_ready_i = ready;
      load_i      = load;
      mode_i      = mode;
      seed0_i     = s0;
      seed1_i     = s1;
      @(posedge clk);
      model_edge(en, ready, load, mode, int'(s0), int'(s1));
      #1;
      chk_model();
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      en_i        = 1'b0;
      out_ready_i = 1'b0;
      load_i      = 1'b0;
      mode_i      = 1'b0;
      seed0_i     = '0;
      seed1_i     = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid_o), 32'd0);
      chk("rst_data",  32'(out_data_o),  32'd0);
      chk("rst_ovf",   32'(ovf_o),       32'd0);
      chk("rst_cnt",   32'(term_cnt_o),  32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // Vector table for the free-running Fibonacci run
   // ---------------------------------------------------------------------
   typedef struct {
      bit          en;
      bit          ready;
      bit          exp_valid;
      int          exp_data;
      bit          exp_ovf;
      int          exp_cnt;
   } vec_t;

   vec_t tbl[15];
   int   fib_exp[15];

   initial begin
      fib_exp = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233,
`ifdef FIB_SEQ_SAT_EN
                  255};
`else
                  121};
`endif
      for (int i = 0; i < 15; i++) begin
         // The push of 144 (edge 13) is the first overflowing step.
         tbl[i] = '{en: 1'b1, ready: 1'b1, exp_valid: 1'b1, exp_data: fib_exp[i],
                    exp_ovf: (i >= 12), exp_cnt: i + 1};
      end

      do_reset();

      // --- table-driven Fibonacci run ---
      for (int i = 0; i < 15; i++) begin
         step(tbl[i].en, tbl[i].ready, 1'b0, 1'b0, '0, '0);
         chk("tbl_valid", 32'(out_valid_o), 32'(tbl[i].exp_valid));
         chk("tbl_data",  32'(out_data_o),  32'(tbl[i].exp_data));
         chk("tbl_ovf",   32'(ovf_o),       32'(tbl[i].exp_ovf));
         chk("tbl_cnt",   32'(term_cnt_o),  32'(tbl[i].exp_cnt));
      end
`ifdef FIB_SEQ_SAT_EN
      step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
      chk("sat_tail0", 32'(out_data_o), 32'd255);
      step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
      chk("sat_tail1", 32'(out_data_o), 32'd255);
`endif

      // --- backpressure: 6 cycles stalled, then drain with continuous flow ---
      do_reset();
      repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      chk("bp_valid", 32'(out_valid_o), 32'd1);
      chk("bp_head",  32'(out_data_o),  32'd0);
      chk("bp_cnt",   32'(term_cnt_o),  32'd4);
      begin
         int drain_exp[5];
         drain_exp = '{1, 1, 2, 3, 5};
         for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
            chk("drain_data",  32'(out_data_o),  32'(drain_exp[k]));
            chk("drain_valid", 32'(out_valid_o), 32'd1);
            chk("drain_cnt",   32'(term_cnt_o),  32'(5 + k));
         end
      end

      // --- subtract-mode reseed ---
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'd10, 8'd3);
      chk("ld_valid", 32'(out_valid_o), 32'd0);
      chk("ld_cnt",   32'(term_cnt_o),  32'd0);
      chk("ld_ovf",   32'(ovf_o),       32'd0);
      step(1'b1, 1'b1, 1'b0, 1'b1, '0, '0);
      chk("sub_first", 32'(out_data_o), 32'd10);
      chk("sub_ovf",   32'(ovf_o),      32'd1);
      step(1'b1, 1'b1, 1'b0, 1'b1, '0, '0);
      chk("sub_second", 32'(out_data_o), 32'd3);
      step(1'b1, 1'b1, 1'b0, 1'b1, '0, '0);
`ifdef FIB_SEQ_SAT_EN
      chk("sub_third", 32'(out_data_o), 32'd0);
`else
      chk("sub_third", 32'(out_data_o), 32'd249);
`endif

      // --- load with 3 entries queued and ovf set ---
      repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
      chk("q3_valid", 32'(out_valid_o), 32'd1);
      step(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1);
      chk("flush_valid", 32'(out_valid_o), 32'd0);
      chk("flush_data",  32'(out_data_o),  32'd0);
      chk("flush_cnt",   32'(term_cnt_o),  32'd0);
      chk("flush_ovf",   32'(ovf_o),       32'd0);

      // --- asynchronous reset mid-stream ---
      step(1'b1, 1'b0, 1'b1, 1'b1, 8'd10, 8'd3);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid_o), 32'd0);
      chk("arst_data",  32'(out_data_o),  32'd0);
      chk("arst_ovf",   32'(ovf_o),       32'd0);
      chk("arst_cnt",   32'(term_cnt_o),  32'd0);
      model_reset();
      @(posedge clk);
      #3;
      rst = 1'b0;
      // Generation resumes from the parameter seeds.
      step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
      step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
      chk("arst_resume", 32'(out_data_o), 32'd1);

      // --- randomized traffic against the model ---
      for (int n = 0; n < 600; n++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 40) == 0, 1'($urandom_range(0, 1)),
              W'($urandom), W'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fib_seq_gen.md
# fib_seq_gen

Parametrised two-term recurrence sequence generator with a buffered valid/ready output stream. It generalises the team's fixed 8-bit Fibonacci state machine: data width and seeds are configurable, there is add/subtract mode selection, runtime reseeding and an output FIFO, and overflow is flagged. It sits as a stimulus source ahead of downstream datapath blocks, which pull terms at their own rate.

## Interface
- WIDTH, 8: term width in bits (≥2).
- DEPTH, 4: output FIFO entries, power of two, ≥2.
- SEED0, 0: reset value of current term `a`.
- SEED1, 1: reset value of next term `b`.
- CNT_W, 16: width of the generated-term counter.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- en_i  in  1  generate one term per cycle while high and FIFO not full.
- mode_i  in  1  recurrence select: 0 = add (b' = a+b), 1 = subtract (b' = b−a).
- load_i  in  1  synchronous reseed and flush; has priority over everything else.
- seed0_i  in  WIDTH  value loaded into `a` on load_i.
- seed1_i  in  WIDTH  value loaded into `b` on load_i.
- out_valid_o  out  1  FIFO non-empty.
- out_ready_i  in  1  consumer accepts head when out_valid_o is high.
- out_data_o  out  WIDTH  FIFO head; 0 when empty.
- ovf_o  out  1  sticky arithmetic overflow/underflow flag.
- term_cnt_o  out  CNT_W  number of terms pushed since reset/load; wraps.

## Operation
- State: `a`, `b` (WIDTH each), FIFO storage, read/write pointers, occupancy count (log2(DEPTH)+1 bits), ovf, term_cnt.
- Push condition: `push = en_i & ~load_i & (~full | pop)`, where `pop = out_valid_o & out_ready_i & ~load_i`.
- On push: FIFO[wr] ← a; a ← b; b ← f(a,b); term_cnt += 1 (mod 2^CNT_W).
- f, add mode: the WIDTH+1-bit sum a+b. If the carry-out is 1, set ovf and b takes the low WIDTH bits.
- f, subtract mode: the difference b−a. If a > b, set ovf and b takes the result mod 2^WIDTH.
- mode_i is sampled only on push cycles, so it may change between any two terms.
- Pop: the read pointer advances and the next entry becomes the head.
- Simultaneous push and pop: allowed even when full. Occupancy is unchanged.
- Pop when empty is ignored. en_i when full without a pop stalls, and `a`/`b` are held.
- load_i: a ← seed0_i, b ← seed1_i. Pointers and occupancy are cleared (FIFO flushed), ovf ← 0, term_cnt ← 0. en_i and out_ready_i are ignored that cycle.
- rst (asynchronous) forces a=SEED0, b=SEED1, empty FIFO, ovf=0, term_cnt=0, out_valid_o=0, out_data_o=0. An operation in flight at reset is discarded.

## Timing
- A term pushed at edge N is visible on out_data_o with out_valid_o=1 after edge N (1-cycle latency, first-word-fall-through).
- Throughput is one term per cycle when en_i=1 and out_ready_i=1 continuously.
- out_valid_o, out_data_o, ovf_o and term_cnt_o are registered or derived from registers only. There is no combinational path from any input to any output.
- out_ready_i affects a push in the same cycle only through the full-with-pop rule. This is an internal path and does not reach an output.
- ovf_o rises after the edge where the overflowing push occurs, then holds until load_i or rst.

## Configuration
- FIB_SEQ_SAT_EN defined:
  - Add-mode overflow clamps b to 2^WIDTH−1.
  - Subtract-mode underflow clamps b to 0.
  - ovf_o is still set.
- FIB_SEQ_SAT_EN undefined: results wrap modulo 2^WIDTH as described above.

## Test plan
- Reset, defaults (WIDTH=8), en_i=1, out_ready_i=1:
  - Outputs 0,1,1,2,3,5,8,13,21,34,55,89,144,233,121.
  - ovf_o rises after the push of 144.
  - term_cnt_o=15 after 15 pushes.
- Same as above with FIB_SEQ_SAT_EN defined: outputs …,144,233,255,255,255 and ovf_o=1.
- Backpressure:
  - out_ready_i=0, en_i=1 for 6 cycles: exactly 4 pushes, out_valid_o=1, head=0.
  - Then out_ready_i=1: 0,1,1,2 drain in order, then generation continues with 3,5.
- Full FIFO, en_i=1 and out_ready_i=1 together: occupancy stays 4 and one term in, one term out per cycle with no gap.
- Subtract reseed: load_i with seed0_i=10, seed1_i=3, mode_i=1, then en_i=1:
  - First output 10, next 3.
  - Without FIB_SEQ_SAT_EN the third output is 249 and ovf_o=1.
  - With FIB_SEQ_SAT_EN the third output is 0.
- Disruption mid-stream:
  - load_i asserted with 3 entries queued: out_valid_o=0 next cycle, term_cnt_o=0, ovf_o=0.
  - rst asserted asynchronously mid-stream: all outputs go to their reset values immediately.
